led_serial_receiver: RTL and testbench

//   Receive end of the Controller's LED-driver serial link (serial/sclk/lat/gsclk).

---
 rtl/led_serial_receiver.sv | 160 ++++++++++++++++
 tb/tb_led_serial_receiver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/led_serial_receiver.sv
// LED-driver serial link receiver: synchronised shift-in, latch commit and per-channel PWM.
// Optional daisy-chain output `sout` when LED_RX_SOUT_EN is defined.
module led_serial_receiver #(
  parameter int CHANNELS = 4,
  parameter int GS_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         serial,
  input  logic                         sclk,
  input  logic                         lat,
  input  logic                         gsclk,
  output logic [CHANNELS*GS_BITS-1:0]  gs_data,
  output logic [CHANNELS-1:0]          pwm,
  output logic                         frame_valid,
  output logic                         frame_err,
  output logic [1:0]                   rx_state
`ifdef LED_RX_SOUT_EN
  ,
  output logic                         sout
`endif
);

  localparam int FRAME = CHANNELS * GS_BITS;
  localparam int CW    = $clog2(FRAME + 2);

  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]      CNT_FRAME = CW'(FRAME);
  localparam logic [CW-1:0]      CNT_MAX   = CW'(FRAME + 1);
  localparam logic [GS_BITS-1:0] GS_ONE    = GS_BITS'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SHIFT   = 2'b01,
    FULL    = 2'b10,
    OVERRUN = 2'b11
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [FRAME-1:0]   shreg;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_inc;
  logic [GS_BITS-1:0] gs_cnt;

  logic [1:0] ser_q;
  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] s3;

  logic serial_s;
  logic sclk_rise;
  logic lat_s;
  logic lat_rise;
  logic gs_rise;
  logic shift_en;
  logic latch_ok;
  logic latch_bad;

  // Serial is a level sampled on sclk rise, so it needs no edge stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_q <= '0;
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
    end else begin
      ser_q <= {ser_q[0], serial};
      s1    <= {gsclk, lat, sclk};
      s2    <= s1;
      s3    <= s2;
    end
  end

  assign serial_s  = ser_q[1];
  assign sclk_rise = s2[0] & ~s3[0];
  assign lat_s     = s2[1];
  assign lat_rise  = s2[1] & ~s3[1];
  assign gs_rise   = s2[2] & ~s3[2];
  assign shift_en  = sclk_rise & ~lat_s;
  assign cnt_inc   = cnt + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (lat_rise) begin
      state_n = IDLE;
    end else if (shift_en) begin
      unique case (state)
        IDLE:    state_n = (cnt_inc == CNT_FRAME) ? FULL : SHIFT;
        SHIFT:   state_n = (cnt_inc == CNT_FRAME) ? FULL : SHIFT;
        FULL:    state_n = OVERRUN;
        OVERRUN: state_n = OVERRUN;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    latch_ok  = 1'b0;
    latch_bad = 1'b0;
    rx_state  = state;
    unique case (1'b1)
      (lat_rise && state == FULL): latch_ok  = 1'b1;
      (lat_rise && state != FULL): latch_bad = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (shift_en)
        shreg <= {shreg[FRAME-2:0], serial_s};
      if (lat_rise)
        cnt <= '0;
      else if (shift_en && cnt != CNT_MAX)
        cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gs_data     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= latch_ok;
      if (latch_ok) begin
        gs_data   <= shreg;
        frame_err <= 1'b0;
      end else if (latch_bad) begin
        frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gs_cnt <= '0;
      pwm    <= '0;
    end else begin
      if (gs_rise)
        gs_cnt <= gs_cnt + GS_ONE;
      for (int i = 0; i < CHANNELS; i++)
        pwm[i] <= gs_data[i*GS_BITS +: GS_BITS] > gs_cnt;
    end
  end

`ifdef LED_RX_SOUT_EN
  assign sout = shreg[FRAME-1];
`endif

endmodule

// File: tb/tb_led_serial_receiver.sv
// Directed self-checking bench for led_serial_receiver.
// Covers reset, frame commit, PWM duty, bad latches, overrun and mid-frame reset.
module tb_led_serial_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        serial = 1'b0;
  logic        sclk = 1'b0;
  logic        lat = 1'b0;
  logic        gsclk = 1'b0;
  logic [31:0] gs_data;
  logic [3:0]  pwm;
  logic        frame_valid;
  logic        frame_err;
  logic [1:0]  rx_state;
`ifdef LED_RX_SOUT_EN
  logic        sout;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;
  int fv_base;
  int hi [4];

  led_serial_receiver #(.CHANNELS(4), .GS_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .serial      (serial),
    .sclk        (sclk),
    .lat         (lat),
    .gsclk       (gsclk),
    .gs_data     (gs_data),
    .pwm         (pwm),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .rx_state    (rx_state)
`ifdef LED_RX_SOUT_EN
    ,
    .sout        (sout)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (frame_valid) fv_cnt <= fv_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      serial = w[31 - (i % 32)];
      wait_clk(3);
      sclk = 1'b1;
      wait_clk(3);
      sclk = 1'b0;
    end
    wait_clk(5);
  endtask

  task automatic pulse_lat();
    lat = 1'b1;
    wait_clk(4);
    lat = 1'b0;
    wait_clk(6);
  endtask

  task automatic pulse_gs();
    gsclk = 1'b1;
    wait_clk(3);
    gsclk = 1'b0;
    wait_clk(4);
  endtask

  initial begin
    wait_clk(3);
    rst = 1'b0;
    wait_clk(50);
    chk("reset_gs_data", gs_data, 32'h0);
    chk("reset_pwm", {28'h0, pwm}, 32'h0);
    chk("reset_fv", {31'h0, frame_valid}, 32'h0);
    chk("reset_err", {31'h0, frame_err}, 32'h0);
    chk("reset_state", {30'h0, rx_state}, 32'h0);

    send_bits(32'h04010000, 1);
    chk("state_shift", {30'h0, rx_state}, 32'h1);
    send_bits(32'h04010000 << 1, 31);
    chk("state_full", {30'h0, rx_state}, 32'h2);
    fv_base = fv_cnt;
    pulse_lat();
    chk("f1_gs_data", gs_data, 32'h04010000);
    chk("f1_fv_pulses", fv_cnt - fv_base, 1);
    chk("f1_err", {31'h0, frame_err}, 32'h0);
    chk("f1_state_idle", {30'h0, rx_state}, 32'h0);

    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int k = 0; k < 256; k++) begin
      for (int c = 0; c < 4; c++) if (pwm[c]) hi[c]++;
      pulse_gs();
    end
    chk("pwm3_hi_cnt", hi[3], 4);
    chk("pwm2_hi_cnt", hi[2], 1);
    chk("pwm1_hi_cnt", hi[1], 0);
    chk("pwm0_hi_cnt", hi[0], 0);

    fv_base = fv_cnt;
    send_bits(32'hFFFFFFFF, 31);
    chk("b31_state", {30'h0, rx_state}, 32'h1);
    pulse_lat();
    chk("b31_err", {31'h0, frame_err}, 32'h1);
    chk("b31_gs_kept", gs_data, 32'h04010000);
    chk("b31_no_fv", fv_cnt - fv_base, 0);

    send_bits(32'h12345678, 33);
    chk("b33_overrun", {30'h0, rx_state}, 32'h3);
    pulse_lat();
    chk("b33_err", {31'h0, frame_err}, 32'h1);
    chk("b33_gs_kept", gs_data, 32'h04010000);
    chk("b33_state_idle", {30'h0, rx_state}, 32'h0);

    fv_base = fv_cnt;
    send_bits(32'hFF000080, 32);
    pulse_lat();
    chk("f2_gs_data", gs_data, 32'hFF000080);
    chk("f2_err_clr", {31'h0, frame_err}, 32'h0);
    chk("f2_fv_pulses", fv_cnt - fv_base, 1);
    for (int k = 0; k < 256; k++) begin
      chk($sformatf("f2_pwm3_k%0d", k), {31'h0, pwm[3]},
          (k != 255) ? 32'h1 : 32'h0);
      chk($sformatf("f2_pwm0_k%0d", k), {31'h0, pwm[0]},
          (k < 128) ? 32'h1 : 32'h0);
      pulse_gs();
    end

    send_bits(32'hDEADBEEF, 16);
    chk("mid_state", {30'h0, rx_state}, 32'h1);
    rst = 1'b1;
    wait_clk(2);
    chk("rst_state", {30'h0, rx_state}, 32'h0);
    chk("rst_gs_data", gs_data, 32'h0);
    chk("rst_pwm", {28'h0, pwm}, 32'h0);
    chk("rst_err", {31'h0, frame_err}, 32'h0);
    rst = 1'b0;
    wait_clk(5);
    fv_base = fv_cnt;
    send_bits(32'h5AC33CA5, 32);
    pulse_lat();
    chk("f3_gs_data", gs_data, 32'h5AC33CA5);
    chk("f3_err", {31'h0, frame_err}, 32'h0);
    chk("f3_fv_pulses", fv_cnt - fv_base, 1);

`ifdef LED_RX_SOUT_EN
    begin
      logic [31:0] prev;
      prev = 32'h5AC33CA5;
      chk("sout_k0", {31'h0, sout}, {31'h0, prev[31]});
      for (int k = 1; k < 32; k++) begin
        send_bits(32'h0F0F0F0F << (k - 1), 1);
        chk($sformatf("sout_k%0d", k), {31'h0, sout},
            {31'h0, prev[31 - k]});
      end
      pulse_lat();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
